// File: rtl/add_04bit_cla_if.sv
// Operand/result bundle for the 4-bit carry-lookahead adder.
// The master drives operands and reads results; the slave is the adder.
interface add_04bit_cla_if;
  logic       i_en;
  logic [3:0] i_num_a;
  logic [3:0] i_num_b;
  logic       i_cry;
  logic [3:0] o_res;
  logic       o_cry;
  logic       o_gen;
  logic       o_pro;
  logic       o_vld;

  modport master (
    output i_en, i_num_a, i_num_b, i_cry,
    input  o_res, o_cry, o_gen, o_pro, o_vld
  );

  modport slave (
    input  i_en, i_num_a, i_num_b, i_cry,
    output o_res, o_cry, o_gen, o_pro, o_vld
  );
endinterface

// File: rtl/add_04bit_cla.sv
// 4-bit carry-lookahead adder with optional output register stage.
// Group generate/propagate are exported so the adder can cascade into wider lookahead trees.
module add_04bit_cla #(
  parameter bit REG_OUT = 1'b1
) (
  input logic           i_clk,
  input logic           i_rst,
  add_04bit_cla_if.slave bus
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic [3:0] sum;
  logic       grp_g;
  logic       grp_p;

  assign a = bus.i_num_a;
  assign b = bus.i_num_b;

  // Every carry is a flat sum of products over g/p/cin, so no carry waits on another.
  always_comb begin
    g     = a & b;
    p     = a ^ b;
    c[0]  = bus.i_cry;
    c[1]  = g[0]
          | (p[0] & c[0]);
    c[2]  = g[1]
          | (p[1] & g[0])
          | (p[1] & p[0] & c[0]);
    c[3]  = g[2]
          | (p[2] & g[1])
          | (p[2] & p[1] & g[0])
          | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sum   = p ^ c[3:0];
    grp_g = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
  end

  generate
    if (REG_OUT) begin : gen_reg
      logic [3:0] res_q;
      logic       cry_q;
      logic       gen_q;
      logic       pro_q;
      logic       vld_q;

      // Results load only on enabled edges; valid tracks the enable of the latest edge.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          res_q <= 4'h0;
          cry_q <= 1'b0;
          gen_q <= 1'b0;
          pro_q <= 1'b0;
          vld_q <= 1'b0;
        end else begin
          vld_q <= bus.i_en;
          if (bus.i_en) begin
            res_q <= sum;
            cry_q <= c[4];
            gen_q <= grp_g;
            pro_q <= grp_p;
          end
        end
      end

      assign bus.o_res = res_q;
      assign bus.o_cry = cry_q;
      assign bus.o_gen = gen_q;
      assign bus.o_pro = pro_q;
      assign bus.o_vld = vld_q;
    end else begin : gen_comb
      assign bus.o_res = sum;
      assign bus.o_cry = c[4];
      assign bus.o_gen = grp_g;
      assign bus.o_pro = grp_p;
      assign bus.o_vld = bus.i_en & ~i_rst;
    end
  endgenerate

endmodule

// File: tb/tb_add_04bit_cla.sv
// Self-checking bench for add_04bit_cla: registered build against a plain-arithmetic model,
// plus a combinational build sampled without waiting for a clock edge.
module tb_add_04bit_cla;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  add_04bit_cla_if bus_r ();
  add_04bit_cla_if bus_c ();

  add_04bit_cla #(.REG_OUT(1'b1)) dut_reg (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_r.slave)
  );

  add_04bit_cla #(.REG_OUT(1'b0)) dut_comb (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_c.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {vld, pro, gen, cry, res} from plain addition.
  function automatic logic [7:0] refModel(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin, input logic vld);
    int base;
    int total;
    logic [4:0] t5;
    base  = int'(a) + int'(b);
    total = base + int'(cin);
    t5    = 5'(total);
    return {vld, (base == 15), (base >= 16), t5};
  endfunction

  function automatic logic [7:0] observeReg();
    return {bus_r.o_vld, bus_r.o_pro, bus_r.o_gen, bus_r.o_cry, bus_r.o_res};
  endfunction

  function automatic logic [7:0] observeComb();
    return {bus_c.o_vld, bus_c.o_pro, bus_c.o_gen, bus_c.o_cry, bus_c.o_res};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%02h expected=%02h (vld,pro,gen,cry,res[3:0])", tag, got, exp);
    end
  endtask

  // Drive operands, take one rising edge, sample 1 time unit after it.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic cin, input logic en);
    bus_r.i_num_a = a;
    bus_r.i_num_b = b;
    bus_r.i_cry   = cin;
    bus_r.i_en    = en;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
  } vec_t;

  vec_t        vecs[11];
  logic [7:0]  held;
  logic [3:0]  ra;
  logic [3:0]  rb;
  logic        rc;
  logic        ren;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus_r.i_en = 1'b0; bus_r.i_num_a = 4'h0; bus_r.i_num_b = 4'h0; bus_r.i_cry = 1'b0;
    bus_c.i_en = 1'b1; bus_c.i_num_a = 4'hF; bus_c.i_num_b = 4'hF; bus_c.i_cry = 1'b1;

    #3;
    checkOutput("reset_state", observeReg(), 8'h00);
    checkOutput("comb_vld_in_reset", {7'h0, bus_c.o_vld}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("first_after_reset", observeReg(), refModel(4'h0, 4'h0, 1'b0, 1'b1));

    vecs[0]  = '{4'hF, 4'hF, 1'b0};
    vecs[1]  = '{4'hC, 4'h9, 1'b0};
    vecs[2]  = '{4'h7, 4'h6, 1'b0};
    vecs[3]  = '{4'h5, 4'h5, 1'b1};
    vecs[4]  = '{4'hE, 4'h9, 1'b1};
    vecs[5]  = '{4'h2, 4'h6, 1'b1};
    vecs[6]  = '{4'h6, 4'hC, 1'b1};
    vecs[7]  = '{4'h5, 4'hA, 1'b0};
    vecs[8]  = '{4'h5, 4'hA, 1'b1};
    vecs[9]  = '{4'h0, 4'h0, 1'b0};
    vecs[10] = '{4'hA, 4'h5, 1'b1};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      checkOutput($sformatf("directed_%0d", i), observeReg(),
                  refModel(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1));
    end
    checkOutput("full_prop_res", {3'h0, bus_r.o_cry, bus_r.o_res}, 8'h10);

    applyStimulus(4'h3, 4'h4, 1'b0, 1'b1);
    checkOutput("hold_load", observeReg(), 8'h87);
    applyStimulus(4'hF, 4'hF, 1'b0, 1'b0);
    checkOutput("hold_keep", observeReg(), 8'h07);
    applyStimulus(4'hF, 4'hF, 1'b1, 1'b1);
    checkOutput("reload", observeReg(), refModel(4'hF, 4'hF, 1'b1, 1'b1));

    // Asynchronous reset mid-cycle, then an enabled edge during reset must capture nothing.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", observeReg(), 8'h00);
    applyStimulus(4'h9, 4'h9, 1'b1, 1'b1);
    checkOutput("no_capture_in_reset", observeReg(), 8'h00);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1);
    checkOutput("resume_after_reset", observeReg(), 8'h80);

    for (int i = 0; i < 512; i++) begin
      ra = 4'(i >> 5);
      rb = 4'(i >> 1);
      rc = i[0];
      applyStimulus(ra, rb, rc, 1'b1);
      checkOutput($sformatf("exh_%0h_%0h_%0d", ra, rb, rc), observeReg(),
                  refModel(ra, rb, rc, 1'b1));
    end

    held = observeReg();
    for (int i = 0; i < 300; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rc  = 1'($urandom_range(0, 1));
      ren = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rc, ren);
      if (ren) held = refModel(ra, rb, rc, 1'b1);
      else     held = {1'b0, held[6:0]};
      checkOutput($sformatf("rand_%0d", i), observeReg(), held);
    end

    // Combinational build: checked without waiting for an edge.
    @(negedge clk);
    bus_c.i_num_a = 4'hC; bus_c.i_num_b = 4'h9; bus_c.i_cry = 1'b0; bus_c.i_en = 1'b1;
    #1;
    checkOutput("comb_c_9", observeComb(), refModel(4'hC, 4'h9, 1'b0, 1'b1));
    checkOutput("comb_c_9_sum", {3'h0, bus_c.o_cry, bus_c.o_res}, 8'h15);
    for (int i = 0; i < 40; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rc  = 1'($urandom_range(0, 1));
      ren = 1'($urandom_range(0, 1));
      bus_c.i_num_a = ra; bus_c.i_num_b = rb; bus_c.i_cry = rc; bus_c.i_en = ren;
      #1;
      checkOutput($sformatf("comb_rand_%0d", i), observeComb(), refModel(ra, rb, rc, ren));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
